// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing slice: pixel geometry,
// processor mode encoding and the pixel packer state encoding.
package img_proc_pkg;

  localparam int COLOR_SIZE = 8;
  localparam int PIXEL_SIZE = 3 * COLOR_SIZE;

  // Operating mode of the threshold/brightness processor.
  typedef enum logic [1:0] {
    NONE       = 2'd0,
    THRESHOLD  = 2'd1,
    BRIGHTNESS = 2'd2,
    RESERVED   = 2'd3
  } mode_e;

  // Pixel packer frame states.
  typedef enum logic [1:0] {
    PACK      = 2'd0,
    FLUSH     = 2'd1,
    WAIT_DONE = 2'd2
  } packer_state_e;

endpackage

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs 24-bit {B,G,R} pixels little-endian into
// DATA_WIDTH-bit words (32 or 64) for the threshold/brightness processor,
// driving its vld / last_data / data_in, and holds off the next frame until
// the processor pulses proc_done.
//
// Optional build macro PACKER_STATS_EN adds the frame_words output, a
// saturating count of words emitted in the current frame.
//
// Handshake: a pixel transfers on a rising clk edge when pix_vld && pix_rdy;
// upstream holds pix_in/pix_last stable while pix_vld=1 and pix_rdy=0.
// The word side has no backpressure: word_vld is a one-cycle pulse per word
// and word_last is only ever high together with word_vld.
//
// The frame state is held in the internal signal 'state' (packer_state_e)
// so it can be observed by name.
module pixel_word_packer
  import img_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_SIZE-1:0] pix_in,
  input  logic                  pix_vld,
  input  logic                  pix_last,
  output logic                  pix_rdy,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_vld,
  output logic                  word_last,
`ifdef PACKER_STATS_EN
  output logic [15:0]           frame_words,
`endif
  input  logic                  proc_done
);

  // Accumulator holds one full word plus one pixel of overhang.
  localparam int         ACC_W    = DATA_WIDTH + PIXEL_SIZE;
  localparam logic [6:0] DW_BITS  = 7'(DATA_WIDTH);
  localparam logic [6:0] PIX_BITS = 7'(PIXEL_SIZE);

  packer_state_e    state;
  logic [ACC_W-1:0] acc;
  logic [6:0]       fill;

  logic             accept;
  logic [ACC_W-1:0] acc_ins;
  logic [ACC_W-1:0] acc_shift;
  logic [6:0]       fill_add;
  logic             word_full;

  // Insert the incoming pixel at the current fill offset and precompute the
  // post-emission remainder; bits above fill are always zero, so residual
  // words come out zero-padded without extra masking.
  always_comb begin
    accept    = pix_vld && pix_rdy;
    acc_ins   = acc | (ACC_W'(pix_in) << fill);
    fill_add  = fill + PIX_BITS;
    word_full = (fill_add >= DW_BITS);
    acc_shift = acc_ins >> DATA_WIDTH;
  end

  // Frame FSM with registered handshake and word outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PACK;
      acc       <= '0;
      fill      <= '0;
      word_out  <= '0;
      word_vld  <= 1'b0;
      word_last <= 1'b0;
      pix_rdy   <= 1'b0;
    end else begin
      word_vld  <= 1'b0;
      word_last <= 1'b0;
      case (state)
        PACK: begin
          pix_rdy <= 1'b1;
          if (accept) begin
            if (word_full) begin
              // A full word is available: emit it, keep the overhang.
              word_out <= acc_ins[DATA_WIDTH-1:0];
              word_vld <= 1'b1;
              acc      <= acc_shift;
              fill     <= fill_add - DW_BITS;
              if (pix_last) begin
                pix_rdy <= 1'b0;
                if (fill_add == DW_BITS) begin
                  // Frame ends exactly on a word boundary.
                  word_last <= 1'b1;
                  acc       <= '0;
                  fill      <= '0;
                  state     <= WAIT_DONE;
                end else begin
                  // Overhang still pending; emit it next cycle.
                  state <= FLUSH;
                end
              end
            end else begin
              acc  <= acc_ins;
              fill <= fill_add;
              if (pix_last) begin
                // Short final word: residual bits, zero-padded above.
                word_out  <= acc_ins[DATA_WIDTH-1:0];
                word_vld  <= 1'b1;
                word_last <= 1'b1;
                acc       <= '0;
                fill      <= '0;
                pix_rdy   <= 1'b0;
                state     <= WAIT_DONE;
              end
            end
          end
        end

        FLUSH: begin
          pix_rdy   <= 1'b0;
          word_out  <= acc[DATA_WIDTH-1:0];
          word_vld  <= 1'b1;
          word_last <= 1'b1;
          acc       <= '0;
          fill      <= '0;
          state     <= WAIT_DONE;
        end

        WAIT_DONE: begin
          pix_rdy <= proc_done;
          if (proc_done) begin
            fill  <= '0;
            state <= PACK;
          end
        end

        default: begin
          pix_rdy <= 1'b0;
          acc     <= '0;
          fill    <= '0;
          state   <= PACK;
        end
      endcase
    end
  end

`ifdef PACKER_STATS_EN
  logic emit;
  logic new_frame;

  // A word leaves on the next edge: a pixel that fills a word or ends the
  // frame, or the FLUSH residual.
  always_comb begin
    emit = ((state == PACK) && accept && (word_full || pix_last)) ||
           (state == FLUSH);
  end

  // Per-frame word counter; restarts on the first pixel after a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_words <= '0;
      new_frame   <= 1'b0;
    end else begin
      if ((state == WAIT_DONE) && proc_done) begin
        new_frame <= 1'b1;
      end
      if ((state == PACK) && accept && new_frame) begin
        new_frame   <= 1'b0;
        frame_words <= emit ? 16'd1 : 16'd0;
      end else if (emit && (frame_words != 16'hFFFF)) begin
        frame_words <= frame_words + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Upstream feeder for the threshold/brightness processor.
- Accepts one 24-bit RGB pixel per cycle over a valid/ready handshake and packs pixels little-endian into DATA_WIDTH words.
- Drives the processor's vld / last_data / data_in inputs.
- Holds off the next frame until the processor pulses done.

Parameters:
- DATA_WIDTH, 32, output word width; 32 or 64 only.
- PIXEL_SIZE, 24, bits per pixel (3 x COLOR_SIZE); taken from the shared package.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_in  in  PIXEL_SIZE  pixel {B,G,R}; R in bits [7:0]
- pix_vld  in  1  pix_in valid
- pix_last  in  1  pix_in is the final pixel of the frame
- pix_rdy  out  1  packer can accept a pixel this cycle
- word_out  out  DATA_WIDTH  packed word; goes to processor data_in
- word_vld  out  1  word_out valid; goes to processor vld
- word_last  out  1  final word of frame; goes to processor last_data
- proc_done  in  1  processor done pulse

Behaviour:
- A pixel is accepted on a rising clk edge when pix_vld && pix_rdy.
- Reset (async, any state): state=PACK, accumulator=0, fill=0, word_out=0, word_vld=0, word_last=0. pix_rdy=1 once out of reset. Mid-frame reset discards partial data and emits no word.
- Accumulator: DATA_WIDTH+PIXEL_SIZE bits. fill: 7-bit count of valid bits.
- Each accepted pixel is written at bit offset fill; fill += 24.
- If the new fill >= DATA_WIDTH:
  - Emit the low DATA_WIDTH bits.
  - Shift the accumulator right by DATA_WIDTH; fill -= DATA_WIDTH.
- At most one word per accepted pixel: max pre-add fill < DATA_WIDTH.
- Outputs are registered. A word appears on word_out/word_vld in the cycle after the accepting edge. word_vld is a 1-cycle pulse per word. There is no downstream backpressure.
- States:
  - PACK: pix_rdy=1.
    - Accepted pix_last, new fill == DATA_WIDTH: emit word with word_last=1 -> WAIT_DONE.
    - Accepted pix_last, new fill < DATA_WIDTH: emit the residual zero-padded in the upper bits, word_last=1 -> WAIT_DONE.
    - Accepted pix_last, new fill > DATA_WIDTH: emit the full word with word_last=0 -> FLUSH.
  - FLUSH: pix_rdy=0. Next cycle emit the residual zero-padded, word_last=1; clear accumulator and fill -> WAIT_DONE.
  - WAIT_DONE: pix_rdy=0, no words emitted. proc_done=1 -> PACK with fill=0. proc_done in other states is ignored.
- word_last is asserted only together with word_vld.
- pix_vld with pix_rdy=0 is not accepted; upstream holds its data.

Optional Feature:
- Macro PACKER_STATS_EN.
- Defined: adds output frame_words [15:0].
  - Counts words emitted in the current frame; saturates at 16'hFFFF.
  - Holds its value through WAIT_DONE.
  - Clears on the first pixel accepted in PACK after WAIT_DONE; 0 at reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package img_proc_pkg: COLOR_SIZE=8, PIXEL_SIZE=24, the mode enum (NONE/THRESHOLD/BRIGHTNESS/RESERVED), and the packer state enum (PACK/FLUSH/WAIT_DONE).
- Single module; no sub-module. The accumulator/shift logic is inline.

Test Plan:
- DATA_WIDTH=32; pixels 112233, 445566, 778899, AABBCC, last on the 4th -> words 66112233, 88994455, AABBCC77; word_last on the 3rd word only; pix_rdy=0 afterwards until proc_done.
- Single pixel 123456 with pix_last -> one word 00123456 with word_last=1, one cycle after acceptance; state WAIT_DONE.
- Pixels AAAAAA, BBBBBB, last on the 2nd -> BBAAAAAA (word_last=0) at N+1, then 0000BBBB (word_last=1) at N+2 via FLUSH; pix_rdy=0 during FLUSH.
- DATA_WIDTH=64; 8 pixels, last on the 8th -> exactly 3 words, no FLUSH, word_last on the 3rd. Repeat with 9 pixels -> 4th word carries pixel 8 zero-padded, word_last=1.
- Assert rst_n low mid-frame after 2 pixels -> all outputs 0 immediately. The next frame packs from bit 0 with no stale bits.
- PACKER_STATS_EN defined, 4-pixel frame -> frame_words=3, held through WAIT_DONE, cleared to 0 on the first pixel of the next frame.
